// File: rtl/enc4to2_rr.sv
// Sequential 4-to-2 encoder: sticky pending capture of request lines, one index
// issued per valid/ready transfer with fixed or round-robin priority.
module enc4to2_rr #(
   parameter int unsigned RR = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] y,
   input  logic       ready,
   output logic [1:0] w,
   output logic       valid,
   output logic [3:0] pend
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t     state, state_next;
   logic [1:0] ptr;
   logic [1:0] base;
   logic [1:0] idx;
   logic [1:0] sel;
   logic       found;
   logic       load;
   logic [3:0] clr;
   logic [3:0] pend_next;

   assign valid = (state == HOLD);
   assign load  = en && (pend != '0) && (!valid || ready);

   // Fixed priority is the rotating search anchored permanently at index 0.
   always_comb begin
      base  = (RR != 0) ? ptr : '0;
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = base + 2'(i);
         if (!found && pend[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      clr = '0;
      if (load) clr[sel] = 1'b1;
      pend_next = (pend & ~clr) | (en ? y : 4'b0000);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (load) state_next = HOLD;
         HOLD: begin
            if (ready) state_next = load ? HOLD : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         ptr  <= '0;
         w    <= '0;
      end else begin
         pend <= pend_next;
         if (load) begin
            w   <= sel;
            ptr <= sel + 2'd1;
         end
      end
   end

endmodule

// File: doc/enc4to2_rr.md
# enc4to2_rr

Sequential 4-to-2 encoder that converts one-hot/multi-hot request lines `y[3:0]` back into a 2-bit index `w[1:0]`. It is the encoding end of the 2-to-4 enable decoder interface. Request pulses are captured into a sticky pending register. One index is issued per transfer over a valid/ready handshake, arbitrated by fixed or round-robin priority. It sits between event sources and any consumer that drives the `{w, en}` decoder interface.

## Interface

Parameters:
- `RR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  capture/issue enable.
- `y`  in  4  request lines; bit i requests index i; multi-hot allowed.
- `ready`  in  1  consumer accepts `w` when `valid && ready`.
- `w`  out  2  encoded index, registered.
- `valid`  out  1  `w` holds an unaccepted index, registered.
- `pend`  out  4  pending-request register, for visibility.

## Operation

- Pending capture:
  - Each edge: `pend <= (pend & ~clr) | (en ? y : 4'b0)`.
  - `clr` is the one-hot bit of the index loaded into the output this cycle.
  - Set wins over clear when the same bit is both captured and issued in one cycle.
  - Repeated pulses on a bit that is already pending merge; no counting.
- Output FSM has two states:
  - IDLE (`valid=0`).
  - HOLD (`valid=1`).
- Load condition: `load = en && (pend != 0) && (!valid || ready)`. Selection uses the registered `pend` only; same-cycle `y` is never issued.
- Transitions:
  - IDLE→HOLD on `load`.
  - HOLD→HOLD on `ready && load`, with a new `w`.
  - HOLD→IDLE on `ready && !load`.
  - HOLD with `!ready` holds: `w` and `valid` stay stable.
- Selection:
  - `RR=0`: lowest set index of `pend`.
  - `RR=1`: search from `ptr`, then `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. On each load, `ptr <= sel+1` (2-bit wrap, so 3+1=0).
- `en=0`:
  - New captures are blocked and no new loads occur.
  - `pend`, `ptr` and an outstanding `valid`/`w` are retained.
  - An outstanding index can still be accepted by `ready`.

## Timing

- Reset (async assert, `rst_n=0`): `w=2'b00`, `valid=0`, `pend=4'b0000`, `ptr=0`. Outputs change immediately on assertion, without waiting for `clk`.
- Reset release: the first active edge is the first edge with `rst_n=1`.
- Latency: `y` sampled at edge k → `pend` bit set after edge k → `valid`/`w` presented after edge k+1, provided the output is free. Minimum 2 edges.
- Throughput: one index per cycle while `ready=1` and `pend` is nonzero.
- Reset mid-transfer: pending requests and the unaccepted index are discarded; there is no partial state.
- Simultaneous events:
  - Capture of bit i in the cycle bit i is issued leaves `pend[i]=1`, so it is issued again later.
  - `y=4'b1111` in a single cycle produces four transfers.
- Empty: `pend=0` and IDLE means `valid` stays 0 and `w` holds its last value. The `w` value is don't-care when `valid=0`.

## Test plan

- Reset check: assert `rst_n=0` mid-cycle → `w=0`, `valid=0`, `pend=0` immediately. Release, then hold `y=0` for 5 cycles → `valid` stays 0.
- Single request: `en=1`, `ready=1`, pulse `y=4'b0100` for one cycle → `pend=4'b0100` after 1 edge. After the 2nd edge, `valid=1`, `w=2`. After the 3rd edge, `valid=0`, `pend=0`.
- Round-robin (`RR=1`): `y=4'b1111` for one cycle with `ready=1` → `w` sequence 0,1,2,3 on consecutive cycles. Then `y=4'b1001` → `w` = 0, then 3 (ptr wraps 3→0). With `RR=0` and `y=4'b1010` → 1, then 3.
- Backpressure: `ready=0` with `y=4'b0011` → `valid=1`, `w=0`, held stable for 4 cycles while `pend=4'b0010`. Raise `ready` → `w=1` on the next cycle, then `valid=0`.
- Set/clear collision: with `pend=4'b0001` and the output free, pulse `y=4'b0001` in the load cycle → `w=0` issued and `pend` stays `4'b0001`. Index 0 is issued a second time later.
- Enable gating: `en=0` while `y=4'b1000` → `pend` unchanged, no load. An already-valid `w=1` is still accepted on `ready`. Raise `en` → captures resume.
